// File: rtl/video_mode_ctrl.sv
// Run-time video mode controller: shadowed timing registers, atomic frame-boundary apply, generator reset hold.
// Optional shadow-set validation on commit when VIDEO_MODE_CHECK_EN is defined.
module video_mode_ctrl #(
  parameter int HOLD_CYCLES = 16,
  parameter int TIMEOUT_W   = 22
) (
  input  logic        hdmi_clk,
  input  logic        reset_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_addr,
  input  logic [11:0] cfg_data,
  input  logic        cfg_commit,
  input  logic        next_frame,
  output logic [11:0] h_total,
  output logic [11:0] h_sync,
  output logic [11:0] h_start,
  output logic [11:0] h_end,
  output logic [11:0] v_total,
  output logic [11:0] v_sync,
  output logic [11:0] v_start,
  output logic [11:0] v_end,
  output logic        gen_rst_n,
  output logic        busy,
  output logic        commit_done,
  output logic        timeout,
  output logic        cfg_err
);

  typedef enum logic [1:0] {IDLE, PENDING, APPLY, HOLD} state_t;

  // Index order matches cfg_addr: h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end.
  localparam logic [7:0][11:0] RST_MODE = {12'd1120, 12'd40, 12'd4, 12'd1124,
                                           12'd2109, 12'd189, 12'd43, 12'd2199};
  localparam logic [7:0]           HOLD_LAST = 8'(HOLD_CYCLES - 1);
  // Apply on the edge where the watchdog reaches all-ones.
  localparam logic [TIMEOUT_W-1:0] WD_LAST   = ~TIMEOUT_W'(1);

  state_t                state;
  logic [7:0][11:0]      shadow, shadow_nxt, act;
  logic [7:0]            hold_cnt;
  logic [TIMEOUT_W-1:0]  wd;
  logic                  mode_ok;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  assign h_total = act[0];
  assign h_sync  = act[1];
  assign h_start = act[2];
  assign h_end   = act[3];
  assign v_total = act[4];
  assign v_sync  = act[5];
  assign v_start = act[6];
  assign v_end   = act[7];

  // A write accepted alongside the commit is part of the committed set, so validate the merged view.
  always_comb begin
    shadow_nxt = shadow;
    if (cfg_valid && state == IDLE) shadow_nxt[cfg_addr] = cfg_data;
  end

`ifdef VIDEO_MODE_CHECK_EN
  always_comb begin
    mode_ok = (shadow_nxt[1] < shadow_nxt[2]) && (shadow_nxt[2] < shadow_nxt[3]) &&
              (shadow_nxt[3] <= shadow_nxt[0]) &&
              (shadow_nxt[5] < shadow_nxt[6]) && (shadow_nxt[6] < shadow_nxt[7]) &&
              (shadow_nxt[7] <= shadow_nxt[4]) &&
              (shadow_nxt[0] >= 12'd16) && (shadow_nxt[4] >= 12'd4);
  end
`else
  assign mode_ok = 1'b1;
`endif

  always_ff @(posedge hdmi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      wd          <= '0;
      shadow      <= RST_MODE;
      act         <= RST_MODE;
      gen_rst_n   <= 1'b0;
      commit_done <= 1'b0;
      timeout     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      commit_done <= 1'b0;
      timeout     <= 1'b0;
      cfg_err     <= 1'b0;
      shadow      <= shadow_nxt;
      case (state)
        IDLE: begin
          if (cfg_commit) begin
            if (mode_ok) begin
              state <= PENDING;
              wd    <= '0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        PENDING: begin
          if (next_frame) begin
            state <= APPLY;
          end else if (wd == WD_LAST) begin
            state   <= APPLY;
            timeout <= 1'b1;
            wd      <= wd + 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        APPLY: begin
          act         <= shadow;
          gen_rst_n   <= 1'b0;
          commit_done <= 1'b1;
          hold_cnt    <= '0;
          state       <= HOLD;
        end
        default: begin
          if (hold_cnt == HOLD_LAST) begin
            gen_rst_n <= 1'b1;
            state     <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Scoreboard bench for video_mode_ctrl: stimulus queues expected events, a negedge monitor pops and compares.
module tb_video_mode_ctrl;
  localparam int H  = 16;
  localparam int TW = 8;
  localparam int M  = (1 << TW) - 1;

  logic hdmi_clk, reset_n, cfg_valid, cfg_ready, cfg_commit, next_frame;
  logic [2:0] cfg_addr;
  logic [11:0] cfg_data;
  logic [11:0] h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end;
  logic gen_rst_n, busy, commit_done, timeout, cfg_err;

  video_mode_ctrl #(.HOLD_CYCLES(H), .TIMEOUT_W(TW)) dut (
    .hdmi_clk(hdmi_clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit), .next_frame(next_frame),
    .h_total(h_total), .h_sync(h_sync), .h_start(h_start), .h_end(h_end),
    .v_total(v_total), .v_sync(v_sync), .v_start(v_start), .v_end(v_end),
    .gen_rst_n(gen_rst_n), .busy(busy), .commit_done(commit_done), .timeout(timeout),
    .cfg_err(cfg_err)
  );

  initial hdmi_clk = 1'b0;
  always #5 hdmi_clk = ~hdmi_clk;

  int cyc = 0;
  always @(posedge hdmi_clk) cyc <= cyc + 1;

  typedef enum int {EV_DONE, EV_TMO, EV_ERR, EV_RISE} ev_t;
  typedef struct {
    ev_t              kind;
    int               at;
    logic [7:0][11:0] vals;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;

  localparam logic [7:0][11:0] DEF  = {12'd1120, 12'd40, 12'd4, 12'd1124,
                                       12'd2109, 12'd189, 12'd43, 12'd2199};
  localparam logic [7:0][11:0] M720 = {12'd744, 12'd24, 12'd4, 12'd749,
                                       12'd1539, 12'd259, 12'd39, 12'd1649};

  logic [7:0][11:0] sh, act_now;
  assign act_now = {v_end, v_start, v_sync, v_total, h_end, h_start, h_sync, h_total};

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input ev_t k, input int at, input logic [7:0][11:0] v);
    exp_t e;
    e.kind = k; e.at = at; e.vals = v;
    q.push_back(e);
  endtask

  task automatic handle(input ev_t k);
    exp_t e;
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: got kind %0d at cyc %0d required none", k, cyc);
    end else begin
      e = q.pop_front();
      chk("event_kind", 96'(k), 96'(e.kind));
      chk("event_cycle", 96'(cyc), 96'(e.at));
      if (k == EV_DONE) chk("applied_values", act_now, e.vals);
      if (k == EV_RISE) chk("busy_at_release", 96'(busy), 96'(0));
    end
  endtask

  logic gprev = 1'b0;
  always @(negedge hdmi_clk) begin
    if (commit_done)           handle(EV_DONE);
    if (timeout)               handle(EV_TMO);
    if (cfg_err)               handle(EV_ERR);
    if (gen_rst_n && !gprev)   handle(EV_RISE);
    gprev = gen_rst_n;
  end

  task automatic wr(input logic [2:0] a, input logic [11:0] d);
    int n = 0;
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    while (!cfg_ready && n < 1000) begin @(negedge hdmi_clk); n++; end
    if (!cfg_ready) begin checks++; errors++; $display("FAIL wr_accept: got no ready required ready"); end
    @(negedge hdmi_clk);
    cfg_valid = 1'b0;
    sh[a] = d;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin @(negedge hdmi_clk); n++; end
    if (busy) begin checks++; errors++; $display("FAIL wait_idle: got busy=1 required busy=0"); end
  endtask

  task automatic commit(output int c);
    c = cyc; cfg_commit = 1'b1;
    @(negedge hdmi_clk);
    cfg_commit = 1'b0;
  endtask

  task automatic frame(output int f);
    f = cyc; next_frame = 1'b1;
    push(EV_DONE, f + 2, sh);
    push(EV_RISE, f + 2 + H, '0);
    @(negedge hdmi_clk);
    next_frame = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int c, f, r;
    reset_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    cfg_commit = 1'b0; next_frame = 1'b0; sh = DEF;
    repeat (3) @(negedge hdmi_clk);
    chk("rst_values", act_now, DEF);
    chk("rst_gen_rst_n", 96'(gen_rst_n), 96'(0));
    chk("rst_busy", 96'(busy), 96'(1));
    chk("rst_ready", 96'(cfg_ready), 96'(0));
    chk("rst_pulses", 96'({commit_done, timeout, cfg_err}), 96'(0));

    reset_n = 1'b1;
    push(EV_RISE, cyc + H, '0);
    repeat (H - 1) @(negedge hdmi_clk);
    chk("hold_low_last", 96'(gen_rst_n), 96'(0));
    @(negedge hdmi_clk);
    chk("ready_after_hold", 96'(cfg_ready), 96'(1));

    // next_frame while idle must do nothing
    next_frame = 1'b1; @(negedge hdmi_clk); next_frame = 1'b0;
    @(negedge hdmi_clk);
    chk("idle_frame_ignored", 96'(busy), 96'(0));

    // 720p mode, next_frame 100 cycles after commit
    for (int i = 0; i < 8; i++) wr(3'(i), M720[i]);
    commit(c);
    chk("pend_ready", 96'(cfg_ready), 96'(0));
    chk("pend_busy", 96'(busy), 96'(1));
    repeat (99) @(negedge hdmi_clk);
    chk("pend_values_held", act_now, DEF);
    frame(f);
    chk("apply_values_old", act_now, DEF);
    wait_idle();

    // watchdog apply with next_frame held low
    sh[0] = sh[0];
    commit(c);
    push(EV_TMO, c + 1 + M, '0);
    push(EV_DONE, c + 2 + M, sh);
    push(EV_RISE, c + 2 + M + H, '0);
    @(negedge hdmi_clk);
    wait_idle();

    // same-cycle write+commit, then a write held through PENDING/HOLD
    cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_data = 12'd2000; sh[0] = 12'd2000;
    commit(c);
    cfg_addr = 3'd1; cfg_data = 12'd50;
    chk("held_write_ready", 96'(cfg_ready), 96'(0));
    repeat (5) @(negedge hdmi_clk);
    frame(f);
    r = 0;
    while (!cfg_ready && r < 1000) begin @(negedge hdmi_clk); r++; end
    chk("write_first_idle", 96'(cyc), 96'(f + 2 + H));
    @(negedge hdmi_clk);
    cfg_valid = 1'b0; sh[1] = 12'd50;
    commit(c);
    repeat (3) @(negedge hdmi_clk);
    frame(f);
    wait_idle();

    // reset mid-PENDING discards commit and shadow writes
    wr(3'd2, 12'd300);
    commit(c);
    repeat (3) @(negedge hdmi_clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_values", act_now, DEF);
    chk("async_rst_gen", 96'(gen_rst_n), 96'(0));
    chk("async_rst_busy", 96'(busy), 96'(1));
    sh = DEF;
    @(negedge hdmi_clk);
    reset_n = 1'b1;
    push(EV_RISE, cyc + H, '0);
    @(negedge hdmi_clk);
    wait_idle();
    commit(c);
    repeat (2) @(negedge hdmi_clk);
    frame(f);
    wait_idle();

    // h_start beyond h_total
    wr(3'd2, 12'd2200);
`ifdef VIDEO_MODE_CHECK_EN
    commit(c);
    push(EV_ERR, c + 1, '0);
    @(negedge hdmi_clk);
    chk("bad_mode_busy", 96'(busy), 96'(0));
    chk("bad_mode_values", act_now, DEF);
    wr(3'd2, 12'd189);
`else
    commit(c);
    repeat (2) @(negedge hdmi_clk);
    frame(f);
    wait_idle();
`endif

    repeat (5) @(negedge hdmi_clk);
    chk("queue_empty", 96'(q.size()), 96'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
